// File: rtl/wta_pkg.sv
// Shared types and default build constants for the winner-take-all round controller.
package wta_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    REPORT  = 2'd2,
    INHIBIT = 2'd3
  } wta_state_t;

  localparam int unsigned WTA_N            = 4;
  localparam int unsigned WTA_W            = 8;
  localparam int unsigned WTA_MAX_STEPS    = 64;
  localparam int unsigned WTA_INHIB_CYCLES = 8;

endpackage

// File: rtl/wta_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit.
module wta_prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IdxW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wta_round_ctrl.sv
// Round sequencer for a winner-take-all LIF array: drive currents, catch the first spike,
// report winner or timeout, then hold the array in reset for an inhibition window.
module wta_round_ctrl
  import wta_pkg::*;
#(
  parameter int unsigned N            = WTA_N,
  parameter int unsigned W            = WTA_W,
  parameter int unsigned MAX_STEPS    = WTA_MAX_STEPS,
  parameter int unsigned INHIB_CYCLES = WTA_INHIB_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       in_current,
  output logic [N*W-1:0]       nrn_current,
  output logic                 nrn_rst_n,
  input  logic [N-1:0]         nrn_spike,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 win_none,
  output logic [7:0]           win_steps
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned InhW = (INHIB_CYCLES > 1) ? $clog2(INHIB_CYCLES) : 1;

  localparam logic [7:0]      StepLast = 8'(MAX_STEPS - 1);
  localparam logic [7:0]      StepMax  = 8'(MAX_STEPS);
  localparam logic [InhW-1:0] InhLast  = InhW'((INHIB_CYCLES > 0) ? INHIB_CYCLES - 1 : 0);

  wta_state_t      state_q, state_d;
  logic [N*W-1:0]  cur_q, cur_d;
  logic [N*W-1:0]  nrn_current_q, nrn_current_d;
  logic            nrn_rst_n_q, nrn_rst_n_d;
  logic [7:0]      step_q, step_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [IdxW-1:0] win_idx_q, win_idx_d;
  logic            win_none_q, win_none_d;
  logic [7:0]      win_steps_q, win_steps_d;

  logic [IdxW-1:0] enc_idx;
  logic            enc_any;

  wta_prio_enc #(
    .N    (N),
    .IdxW (IdxW)
  ) u_prio_enc (
    .req (nrn_spike),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    step_d      = step_q;
    inh_d       = inh_q;
    win_idx_d   = win_idx_q;
    win_none_d  = win_none_q;
    win_steps_d = win_steps_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cur_d   = in_current;
          step_d  = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A spike in the final step takes precedence over the timeout.
        if (enc_any) begin
          win_idx_d   = enc_idx;
          win_none_d  = 1'b0;
          win_steps_d = step_q + 8'd1;
          state_d     = REPORT;
        end else if (step_q == StepLast) begin
          win_idx_d   = '0;
          win_none_d  = 1'b1;
          win_steps_d = StepMax;
          state_d     = REPORT;
        end else begin
          step_d = step_q + 8'd1;
        end
      end
      REPORT: begin
        if (win_ready) begin
          if (INHIB_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            inh_d   = '0;
            state_d = INHIBIT;
          end
        end
      end
      INHIBIT: begin
        if (inh_q == InhLast) begin
          state_d = IDLE;
        end else begin
          inh_d = inh_q + InhW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array drive is registered from the next state so it lines up with the RUN cycles exactly.
  always_comb begin
    nrn_current_d = (state_d == RUN) ? cur_d : '0;
    nrn_rst_n_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      nrn_current_q <= '0;
      nrn_rst_n_q   <= 1'b0;
      step_q        <= 8'd0;
      inh_q         <= '0;
      win_idx_q     <= '0;
      win_none_q    <= 1'b0;
      win_steps_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      nrn_current_q <= nrn_current_d;
      nrn_rst_n_q   <= nrn_rst_n_d;
      step_q        <= step_d;
      inh_q         <= inh_d;
      win_idx_q     <= win_idx_d;
      win_none_q    <= win_none_d;
      win_steps_q   <= win_steps_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign win_valid   = (state_q == REPORT);
  assign nrn_current = nrn_current_q;
  assign nrn_rst_n   = nrn_rst_n_q;
  assign win_idx     = win_idx_q;
  assign win_none    = win_none_q;
  assign win_steps   = win_steps_q;

endmodule

// File: tb/tb_wta_round_ctrl.sv
// Directed bench for wta_round_ctrl: default build plus an INHIB_CYCLES=0 build.
module tb_wta_round_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  localparam logic [31:0] V1 = {8'd40, 8'd30, 8'd200, 8'd10};
  localparam logic [31:0] V2 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] V3 = {8'd9, 8'd8, 8'd7, 8'd6};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           in_valid, in_ready, nrn_rst_n, win_valid, win_ready, win_none;
  logic [N*W-1:0] in_current, nrn_current;
  logic [N-1:0]   nrn_spike;
  logic [1:0]     win_idx;
  logic [7:0]     win_steps;

  logic           b_in_valid, b_in_ready, b_nrn_rst_n, b_win_valid, b_win_ready, b_win_none;
  logic [N*W-1:0] b_in_current, b_nrn_current;
  logic [N-1:0]   b_nrn_spike;
  logic [1:0]     b_win_idx;
  logic [7:0]     b_win_steps;

  int n_checks = 0;
  int n_fail   = 0;

  wta_round_ctrl #(
    .N(N), .W(W), .MAX_STEPS(64), .INHIB_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_current(in_current), .nrn_current(nrn_current), .nrn_rst_n(nrn_rst_n),
    .nrn_spike(nrn_spike), .win_valid(win_valid), .win_ready(win_ready),
    .win_idx(win_idx), .win_none(win_none), .win_steps(win_steps)
  );

  wta_round_ctrl #(
    .N(N), .W(W), .MAX_STEPS(64), .INHIB_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_current(b_in_current), .nrn_current(b_nrn_current), .nrn_rst_n(b_nrn_rst_n),
    .nrn_spike(b_nrn_spike), .win_valid(b_win_valid), .win_ready(b_win_ready),
    .win_idx(b_win_idx), .win_none(b_win_none), .win_steps(b_win_steps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_current = '0; nrn_spike = '0; win_ready = 1'b0;
    b_in_valid = 1'b0; b_in_current = '0; b_nrn_spike = '0; b_win_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_nrn_rst_n", 32'(nrn_rst_n), 32'd0);
    chk("rst_nrn_current", nrn_current, 32'd0);
    chk("rst_win_idx", 32'(win_idx), 32'd0);
    chk("rst_win_none", 32'(win_none), 32'd0);
    chk("rst_win_steps", 32'(win_steps), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single winner: neuron 1 spikes in RUN cycle 5.
    win_ready = 1'b1; in_valid = 1'b1; in_current = V1;
    step(1);
    in_valid = 1'b0;
    chk("t1_run_in_ready", 32'(in_ready), 32'd0);
    chk("t1_run_nrn_rst_n", 32'(nrn_rst_n), 32'd1);
    chk("t1_run_current", nrn_current, V1);
    step(5);
    chk("t1_c5_valid", 32'(win_valid), 32'd0);
    nrn_spike = 4'b0010;
    step(1);
    nrn_spike = '0;
    chk("t1_valid", 32'(win_valid), 32'd1);
    chk("t1_idx", 32'(win_idx), 32'd1);
    chk("t1_none", 32'(win_none), 32'd0);
    chk("t1_steps", 32'(win_steps), 32'd6);
    chk("t1_rep_current", nrn_current, 32'd0);
    chk("t1_rep_nrn_rst_n", 32'(nrn_rst_n), 32'd0);
    step(1);
    chk("t1_inh_valid", 32'(win_valid), 32'd0);
    chk("t1_inh_idx_hold", 32'(win_idx), 32'd1);
    step(7);
    chk("t1_inh_last_ready", 32'(in_ready), 32'd0);
    step(1);
    chk("t1_idle_ready", 32'(in_ready), 32'd1);

    // Tie on 4'b1010 in RUN cycle 0; spikes present in IDLE must be ignored.
    win_ready = 1'b0; in_valid = 1'b1; in_current = V2; nrn_spike = 4'b1010;
    step(1);
    in_valid = 1'b0;
    chk("t2_run_valid", 32'(win_valid), 32'd0);
    chk("t2_run_current", nrn_current, V2);
    step(1);
    chk("t2_valid", 32'(win_valid), 32'd1);
    chk("t2_idx", 32'(win_idx), 32'd1);
    chk("t2_steps", 32'(win_steps), 32'd1);
    // Backpressure: result held stable while the array stays cleared.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", 32'(win_valid), 32'd1);
      chk("bp_idx", 32'(win_idx), 32'd1);
      chk("bp_steps", 32'(win_steps), 32'd1);
      chk("bp_none", 32'(win_none), 32'd0);
      chk("bp_nrn_rst_n", 32'(nrn_rst_n), 32'd0);
    end
    win_ready = 1'b1; nrn_spike = '0; in_valid = 1'b1; in_current = V3;
    step(1);
    chk("t2_inh_ready", 32'(in_ready), 32'd0);
    chk("t2_inh_valid", 32'(win_valid), 32'd0);
    step(7);
    chk("t2_inh_last_ready", 32'(in_ready), 32'd0);
    chk("t2_inh_current", nrn_current, 32'd0);
    step(1);
    chk("t2_idle_ready", 32'(in_ready), 32'd1);

    // Held in_valid starts the timeout round on the first IDLE cycle.
    step(1);
    in_valid = 1'b0;
    chk("t3_run_ready", 32'(in_ready), 32'd0);
    chk("t3_run_current", nrn_current, V3);
    step(63);
    chk("t3_c63_valid", 32'(win_valid), 32'd0);
    chk("t3_c63_nrn_rst_n", 32'(nrn_rst_n), 32'd1);
    step(1);
    chk("t3_valid", 32'(win_valid), 32'd1);
    chk("t3_none", 32'(win_none), 32'd1);
    chk("t3_idx", 32'(win_idx), 32'd0);
    chk("t3_steps", 32'(win_steps), 32'd64);
    step(1);
    chk("t3_inh_none_hold", 32'(win_none), 32'd1);
    chk("t3_inh_steps_hold", 32'(win_steps), 32'd64);
    step(8);
    chk("t3_idle_ready", 32'(in_ready), 32'd1);

    // Spike in the last RUN cycle beats the timeout.
    in_valid = 1'b1; in_current = V1;
    step(1);
    in_valid = 1'b0;
    step(63);
    nrn_spike = 4'b1000;
    step(1);
    nrn_spike = '0;
    chk("t4_valid", 32'(win_valid), 32'd1);
    chk("t4_idx", 32'(win_idx), 32'd3);
    chk("t4_none", 32'(win_none), 32'd0);
    chk("t4_steps", 32'(win_steps), 32'd64);
    step(9);
    chk("t4_idle_ready", 32'(in_ready), 32'd1);

    // Reset asserted in RUN cycle 3.
    in_valid = 1'b1; in_current = V2;
    step(1);
    in_valid = 1'b0;
    step(3);
    chk("t5_c3_current", nrn_current, V2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_current", nrn_current, 32'd0);
    chk("t5_rst_nrn_rst_n", 32'(nrn_rst_n), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_idx", 32'(win_idx), 32'd0);
    chk("t5_rst_steps", 32'(win_steps), 32'd0);
    chk("t5_rst_none", 32'(win_none), 32'd0);
    nrn_spike = 4'b0001;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_post_valid", 32'(win_valid), 32'd0);
      chk("t5_post_ready", 32'(in_ready), 32'd1);
    end
    nrn_spike = '0; in_valid = 1'b1; in_current = V3;
    step(1);
    in_valid = 1'b0;
    chk("t5_clean_current", nrn_current, V3);
    nrn_spike = 4'b0100;
    step(1);
    nrn_spike = '0;
    chk("t5_clean_valid", 32'(win_valid), 32'd1);
    chk("t5_clean_idx", 32'(win_idx), 32'd2);
    chk("t5_clean_steps", 32'(win_steps), 32'd1);
    step(9);
    chk("t5_idle_ready", 32'(in_ready), 32'd1);

    // INHIB_CYCLES=0 build: back-to-back rounds with in_valid held.
    b_in_valid = 1'b1; b_in_current = V1;
    step(1);
    b_nrn_spike = 4'b0001;
    step(1);
    chk("b_valid", 32'(b_win_valid), 32'd1);
    chk("b_idx", 32'(b_win_idx), 32'd0);
    chk("b_steps", 32'(b_win_steps), 32'd1);
    step(1);
    chk("b_ready_after_hs", 32'(b_in_ready), 32'd1);
    chk("b_idle_valid", 32'(b_win_valid), 32'd0);
    step(1);
    chk("b_run2_valid", 32'(b_win_valid), 32'd0);
    chk("b_run2_nrn_rst_n", 32'(b_nrn_rst_n), 32'd1);
    chk("b_run2_current", b_nrn_current, V1);
    b_nrn_spike = '0;
    step(1);
    b_nrn_spike = 4'b0100;
    step(1);
    b_nrn_spike = '0;
    b_in_valid = 1'b0;
    chk("b2_valid", 32'(b_win_valid), 32'd1);
    chk("b2_idx", 32'(b_win_idx), 32'd2);
    chk("b2_steps", 32'(b_win_steps), 32'd2);
    step(1);
    chk("b2_ready_after_hs", 32'(b_in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
